lvds_tx_scheduler: RTL and testbench
====================================

# lvds_tx_scheduler

Frame scheduler that sits in the `data_clk` domain directly in front of the LVDS serializer. It emits exactly one byte per `data_clk` cycle on `tx_data`: a training pattern after reset, then idle fill, and framed payloads. Payloads come from two byte-stream requesters, which the block arbitrates round-robin. Each frame is wrapped in start-of-frame, header and XOR-checksum bytes so the far end can realign and validate.

## Interface
Parameters:
- `TRAIN_CYCLES`, 64: bytes of `TRAIN_BYTE` sent after reset release (≥1).
- `MAX_LEN`, 16: maximum payload bytes per frame (1..255).
- `TRAIN_BYTE`, 8'hA5: training pattern.
- `IDLE_BYTE`, 8'hBC: idle fill between frames.
- `SOF_BYTE`, 8'hFB: start-of-frame marker.

Ports:
- `data_clk` in 1: serializer slow clock; sole clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: permits new frame grants.
- `ch_valid` in 2: per-channel byte valid (bit n = channel n).
- `ch_data` in 16: channel n byte at [8n+7:8n].
- `ch_last` in 2: marks final byte of a channel's packet.
- `ch_ready` out 2: byte accepted when valid&ready at edge.
- `tx_data` out 8: registered byte to serializer `tx_in`.
- `tx_frame` out 1: high while `tx_data` carries SOF..checksum.
- `underrun` out 1: one-cycle pulse on aborted frame.
- `frame_count` out 16: completed (non-aborted) frames, wraps at 0xFFFF→0.

## Operation
- States: TRAIN, IDLE, SOF, HDR, PAYLOAD, CHK.
- TRAIN: emit `TRAIN_BYTE`; after `TRAIN_CYCLES` bytes post-release go to IDLE.
- IDLE: emit `IDLE_BYTE`. If `enable` and any `ch_valid`, grant a channel via round-robin and go to SOF.
  - Round-robin rule: the channel not granted last wins ties. After reset ch0 has priority.
- SOF: emit `SOF_BYTE`, then go to HDR.
- HDR: emit {7'b0, grant}, clear checksum and length counter, then go to PAYLOAD.
- PAYLOAD: `ch_ready[grant]`=1; all other `ch_ready` bits are always 0.
  - Each accepted byte is emitted and XORed into the checksum, and the length counter increments.
  - Go to CHK after accepting a byte with `ch_last`, or after the `MAX_LEN`th byte.
  - On a MAX_LEN cut, the remainder continues in a later frame. Its header is the same, and it is subject to normal arbitration.
- CHK: emit the checksum, increment `frame_count`, then go to IDLE.
- Underrun: if `ch_valid[grant]`=0 in PAYLOAD, emit ~checksum, pulse `underrun`, and go to IDLE. `frame_count` is unchanged.
- `enable` low mid-frame has no effect; it blocks only new grants.
- Reset mid-operation forces the following from the next cycle:
  - state TRAIN, `tx_data`=`TRAIN_BYTE`;
  - `ch_ready`=0, counters, grant and priority cleared.

## Timing
- All outputs except `ch_ready` are registered. `ch_ready` is a combinational decode of the state register (no input paths).
- Reset values: `tx_data`=`TRAIN_BYTE`, `tx_frame`=0, `underrun`=0, `frame_count`=0, `ch_ready`=0.
- Latency:
  - A byte accepted at edge k appears on `tx_data` after edge k.
  - A grant decision in IDLE puts SOF on `tx_data` after the next edge.
- Wire frame length = payload+3 bytes.
- Minimum gap between frames is one `IDLE_BYTE`, with no back-to-back frames.
- `tx_frame` is aligned with `tx_data`, including the abort byte.

## Structure
- Shared package `lvds_tx_pkg`: state enum, default byte constants, header encoding function.
- Sub-module `rr_arbiter2`: 2-way round-robin, with inputs req[1:0] and advance, and output grant with a last-grant register. All framing logic stays in the top.

## Test plan
- Reset with `TRAIN_CYCLES`=4 → `tx_data`=A5 during reset plus 4 cycles, then BC steady, `ch_ready`=00.
- ch0 sends 11,22,33 (last on 33) → `tx_data` FB,00,11,22,33,00 then BC; `tx_frame` high for 6 cycles; `frame_count`=1.
- Both channels valid continuously, 1-byte packets 0x5A → frames alternate with headers 00,01,00,…, each separated by exactly one BC.
- `MAX_LEN`=4, ch1 sends 01..06 with last on 06 → frames FB,01,01,02,03,04,04 and FB,01,05,06,03; `frame_count`=2.
- ch0 sends 01,02 then drops valid (no last) → FB,00,01,02,FC, `underrun` pulses once, `frame_count` unchanged, then BC.
- `rst` asserted on the second payload cycle → next cycle `tx_data`=A5, `ch_ready`=00, `frame_count`=0, training restarts.

Source files
------------

// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the LVDS transmit frame scheduler.
// Holds the state encoding, default line bytes and the header encoding.
package lvds_tx_pkg;

  typedef enum logic [2:0] {
    ST_TRAIN,
    ST_IDLE,
    ST_SOF,
    ST_HDR,
    ST_PAYLOAD,
    ST_CHK
  } state_e;

  localparam logic [7:0] DEF_TRAIN_BYTE = 8'hA5;
  localparam logic [7:0] DEF_IDLE_BYTE  = 8'hBC;
  localparam logic [7:0] DEF_SOF_BYTE   = 8'hFB;

  // Header byte carries the granted channel number in its LSB.
  function automatic logic [7:0] hdr_byte(input logic grant);
    return {7'b0, grant};
  endfunction

endpackage

// File: rtl/lvds_tx_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the channel not granted last wins.
// The last-grant register only moves when the caller commits a grant.
module rr_arbiter2 (
  input  logic       data_clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);

  logic last_grant;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant = ~last_grant;
    if (req == 2'b01) begin
      grant = 1'b0;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
  end

  // Resetting to 1 makes ch0 the winner of the first tie.
  always_ff @(posedge data_clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/lvds_tx_scheduler.sv
// Byte-per-cycle frame scheduler in front of the LVDS serializer: training,
// idle fill, and SOF/header/payload/XOR-checksum frames from two requesters.
module lvds_tx_scheduler
  import lvds_tx_pkg::*;
#(
  parameter int         TRAIN_CYCLES = 64,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] TRAIN_BYTE   = DEF_TRAIN_BYTE,
  parameter logic [7:0] IDLE_BYTE    = DEF_IDLE_BYTE,
  parameter logic [7:0] SOF_BYTE     = DEF_SOF_BYTE
) (
  input  logic        data_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  ch_valid,
  input  logic [15:0] ch_data,
  input  logic [1:0]  ch_last,
  output logic [1:0]  ch_ready,
  output logic [7:0]  tx_data,
  output logic        tx_frame,
  output logic        underrun,
  output logic [15:0] frame_count
);

  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_CYCLES - 1);
  localparam logic [7:0]  LEN_LAST   = 8'(MAX_LEN - 1);

  state_e      state;
  logic [15:0] train_cnt;
  logic [7:0]  len_cnt;
  logic [7:0]  chk;
  logic        grant_q;
  logic        arb_grant;
  logic        start;
  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_data;

  assign start = (state == ST_IDLE) && enable && (ch_valid != 2'b00);

  rr_arbiter2 u_arb (
    .data_clk (data_clk),
    .rst      (rst),
    .req      (ch_valid),
    .advance  (start),
    .grant    (arb_grant)
  );

  always_comb begin
    sel_valid = ch_valid[grant_q];
    sel_last  = ch_last[grant_q];
    sel_data  = grant_q ? ch_data[15:8] : ch_data[7:0];
  end

  // Decoded from registers only, so the requester sees no input-to-ready path.
  always_comb begin
    ch_ready = 2'b00;
    if (state == ST_PAYLOAD) begin
      ch_ready[grant_q] = 1'b1;
    end
  end

  // Each state's byte is registered on the edge leaving it, keeping tx_data
  // and tx_frame aligned one cycle behind the state that produced them.
  // NOTE: sequential state uses <= so every branch reads pre-edge values.
  always_ff @(posedge data_clk) begin
    if (rst) begin
      state       <= ST_TRAIN;
      tx_data     <= TRAIN_BYTE;
      tx_frame    <= 1'b0;
      underrun    <= 1'b0;
      frame_count <= 16'd0;
      train_cnt   <= 16'd0;
      len_cnt     <= 8'd0;
      chk         <= 8'd0;
      grant_q     <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        ST_TRAIN: begin
          tx_data  <= TRAIN_BYTE;
          tx_frame <= 1'b0;
          if (train_cnt == TRAIN_LAST) begin
            state <= ST_IDLE;
          end else begin
            train_cnt <= train_cnt + 16'd1;
          end
        end
        ST_IDLE: begin
          tx_data  <= IDLE_BYTE;
          tx_frame <= 1'b0;
          if (start) begin
            grant_q <= arb_grant;
            state   <= ST_SOF;
          end
        end
        ST_SOF: begin
          tx_data  <= SOF_BYTE;
          tx_frame <= 1'b1;
          state    <= ST_HDR;
        end
        ST_HDR: begin
          tx_data  <= hdr_byte(grant_q);
          tx_frame <= 1'b1;
          chk      <= 8'd0;
          len_cnt  <= 8'd0;
          state    <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          tx_frame <= 1'b1;
          if (sel_valid) begin
            tx_data <= sel_data;
            chk     <= chk ^ sel_data;
            len_cnt <= len_cnt + 8'd1;
            if (sel_last || (len_cnt == LEN_LAST)) begin
              state <= ST_CHK;
            end
          end else begin
            // Inverted checksum guarantees the far end rejects the aborted frame.
            tx_data  <= ~chk;
            underrun <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_CHK: begin
          tx_data     <= chk;
          tx_frame    <= 1'b1;
          frame_count <= frame_count + 16'd1;
          state       <= ST_IDLE;
        end
        default: begin
          tx_data  <= TRAIN_BYTE;
          tx_frame <= 1'b0;
          state    <= ST_TRAIN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_tx_scheduler.sv
// Scoreboard bench for lvds_tx_scheduler: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares every byte presented with tx_frame high.
module tb_lvds_tx_scheduler;

  localparam int TRAIN_CYCLES = 4;
  localparam int MAX_LEN      = 4;

  logic        data_clk;
  logic        rst;
  logic        enable;
  logic        v0, v1, l0, l1;
  logic [7:0]  d0, d1;
  logic [1:0]  ch_valid;
  logic [15:0] ch_data;
  logic [1:0]  ch_last;
  logic [1:0]  ch_ready;
  logic [7:0]  tx_data;
  logic        tx_frame;
  logic        underrun;
  logic [15:0] frame_count;

  assign ch_valid = {v1, v0};
  assign ch_data  = {d1, d0};
  assign ch_last  = {l1, l0};

  lvds_tx_scheduler #(
    .TRAIN_CYCLES (TRAIN_CYCLES),
    .MAX_LEN      (MAX_LEN)
  ) dut (
    .data_clk    (data_clk),
    .rst         (rst),
    .enable      (enable),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .ch_last     (ch_last),
    .ch_ready    (ch_ready),
    .tx_data     (tx_data),
    .tx_frame    (tx_frame),
    .underrun    (underrun),
    .frame_count (frame_count)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       urun;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    data_clk = 1'b0;
    forever #5 data_clk = ~data_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bytes are listed lowest byte first; the final one may close the frame.
  task automatic exp_bytes(input logic [63:0] b, input int n, input bit urun_end,
                           input bit mark_last);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{data: b[8*i +: 8],
                        urun: urun_end && (i == n - 1),
                        last: mark_last && (i == n - 1)});
    end
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [7:0] d, input logic l);
    if (ch == 0) begin
      v0 = v; d0 = d; l0 = l;
    end else begin
      v1 = v; d1 = d; l1 = l;
    end
  endtask

  task automatic wait_accept(input int ch);
    int budget = 200;
    @(negedge data_clk);
    while (!ch_ready[ch] && budget > 0) begin
      @(negedge data_clk);
      budget--;
    end
    if (!ch_ready[ch]) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout ch%0d ready %b expected 1", ch, ch_ready);
    end else begin
      @(posedge data_clk);
      #1;
    end
  endtask

  task automatic send_pkt(input int ch, input logic [63:0] b, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      set_ch(ch, 1'b1, b[8*i +: 8], with_last && (i == n - 1));
      wait_accept(ch);
    end
    set_ch(ch, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    int budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge data_clk);
      budget--;
    end
    check("scoreboard_drain", exp_q.size(), 0);
    repeat (2) @(negedge data_clk);
  endtask

  // Called right after rst drops: A5 for the reset cycle plus TRAIN_CYCLES, then BC.
  task automatic check_training();
    for (int i = 0; i <= TRAIN_CYCLES; i++) begin
      @(negedge data_clk);
      check("train_byte", tx_data, 8'hA5);
      if (i == 0) begin
        check("reset_ch_ready", ch_ready, 2'b00);
        check("reset_frame_count", frame_count, 16'd0);
        check("reset_tx_frame", tx_frame, 1'b0);
        check("reset_underrun", underrun, 1'b0);
      end
    end
    @(negedge data_clk);
    check("idle_after_train", tx_data, 8'hBC);
    check("idle_ch_ready", ch_ready, 2'b00);
  endtask

  initial begin : monitor
    exp_t e;
    bit   after_last = 1'b0;
    forever begin
      @(negedge data_clk);
      if (after_last) begin
        check("gap_after_frame", {tx_frame, tx_data}, {1'b0, 8'hBC});
        after_last = 1'b0;
      end
      if (tx_frame === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_frame_byte got %h expected none at %0t", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", tx_data, e.data);
          check("frame_underrun", underrun, e.urun);
          after_last = e.last;
        end
      end else if (tx_frame === 1'b0) begin
        check("idle_underrun", underrun, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    enable = 1'b1;
    set_ch(0, 1'b0, 8'h00, 1'b0);
    set_ch(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge data_clk);
    #1 rst = 1'b0;
    check_training();

    // Single 3-byte packet on ch0.
    exp_bytes(64'h00_33_22_11_00_FB, 6, 1'b0, 1'b1);
    send_pkt(0, 64'h33_22_11, 3, 1'b1);
    drain();
    check("frame_count_single", frame_count, 16'd1);

    // MAX_LEN cut on ch1: remainder goes out as a second frame with the same header.
    exp_bytes(64'h04_04_03_02_01_01_FB, 7, 1'b0, 1'b1);
    exp_bytes(64'h03_06_05_01_FB, 5, 1'b0, 1'b1);
    send_pkt(1, 64'h06_05_04_03_02_01, 6, 1'b1);
    drain();
    check("frame_count_maxlen", frame_count, 16'd3);

    // Both channels contend with 1-byte packets; ch1 was last, so ch0 leads.
    exp_bytes(64'h5A_5A_00_FB, 4, 1'b0, 1'b1);
    exp_bytes(64'h5A_5A_01_FB, 4, 1'b0, 1'b1);
    exp_bytes(64'h5A_5A_00_FB, 4, 1'b0, 1'b1);
    exp_bytes(64'h5A_5A_01_FB, 4, 1'b0, 1'b1);
    fork
      begin
        send_pkt(0, 64'h5A, 1, 1'b1);
        send_pkt(0, 64'h5A, 1, 1'b1);
      end
      begin
        send_pkt(1, 64'h5A, 1, 1'b1);
        send_pkt(1, 64'h5A, 1, 1'b1);
      end
    join
    drain();
    check("frame_count_rr", frame_count, 16'd7);

    // enable low holds off the grant even with data waiting.
    enable = 1'b0;
    set_ch(0, 1'b1, 8'h01, 1'b0);
    repeat (4) begin
      @(negedge data_clk);
      check("disabled_no_ready", ch_ready, 2'b00);
      check("disabled_idle", {tx_frame, tx_data}, {1'b0, 8'hBC});
    end
    enable = 1'b1;

    // Underrun: ch0 stops after 2 bytes without last -> ~(01^02) = FC.
    exp_bytes(64'hFC_02_01_00_FB, 5, 1'b1, 1'b1);
    send_pkt(0, 64'h02_01, 2, 1'b0);
    drain();
    check("frame_count_underrun", frame_count, 16'd7);

    // Reset on the second payload cycle restarts training.
    exp_bytes(64'hAA_00_FB, 3, 1'b0, 1'b0);
    set_ch(0, 1'b1, 8'hAA, 1'b0);
    wait_accept(0);
    set_ch(0, 1'b1, 8'hBB, 1'b0);
    rst = 1'b1;
    @(posedge data_clk);
    #1;
    rst = 1'b0;
    set_ch(0, 1'b0, 8'h00, 1'b0);
    check_training();
    check("reset_scoreboard_empty", exp_q.size(), 0);

    repeat (2) @(negedge data_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
